// File: rtl/cv32e40p_shadow_mem_arbiter.sv
// Arbiter that merges the LSU and the shadow-register save port onto one OBI data port.
// Define CV32E40P_SHADOW_ARB_PERF_EN to build the LSU contention counter.
module cv32e40p_shadow_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lsu_req_i,
  output logic                 lsu_gnt_o,
  output logic                 lsu_rvalid_o,
  input  logic                 lsu_we_i,
  input  logic [3:0]           lsu_be_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [31:0]          lsu_wdata_i,
  output logic [31:0]          lsu_rdata_o,
  input  logic                 shd_req_i,
  output logic                 shd_gnt_o,
  output logic                 shd_rvalid_o,
  input  logic [31:0]          shd_addr_i,
  input  logic [31:0]          shd_wdata_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_addr_o,
  output logic [31:0]          data_wdata_o,
  output logic [CNT_WIDTH-1:0] contention_cnt_o
);

  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOCK_LSU = 2'd1;
  localparam logic [1:0] LOCK_SHD = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [OCNT_W-1:0]          ocnt_q;
  logic                       rdy_q;
  logic                       full, empty, sel_lsu, sel_shd, push, pop;

  assign full  = (ocnt_q == OCNT_W'(MAX_OUTSTANDING));
  assign empty = (ocnt_q == '0);
  assign push  = data_req_o & data_gnt_i;
  assign pop   = data_rvalid_i & ~empty;

  assign lsu_rdata_o  = data_rdata_i;
  assign lsu_rvalid_o = pop & ~owner_q[rd_ptr_q];
  assign shd_rvalid_o = pop & owner_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Selection, next state and the OBI request mux; a locked requester holds the mux until granted.
  always_comb begin
    state_d      = state_q;
    sel_lsu      = 1'b0;
    sel_shd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_q && !full) begin
          if (shd_req_i) begin
            sel_shd = 1'b1;
            if (!data_gnt_i) state_d = LOCK_SHD;
          end else if (lsu_req_i) begin
            sel_lsu = 1'b1;
            if (!data_gnt_i) state_d = LOCK_LSU;
          end
        end
      end
      LOCK_LSU: begin
        sel_lsu = lsu_req_i;
        if (data_gnt_i || !lsu_req_i) state_d = IDLE;
      end
      LOCK_SHD: begin
        sel_shd = shd_req_i;
        if (data_gnt_i || !shd_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    data_req_o   = sel_lsu | sel_shd;
    lsu_gnt_o    = sel_lsu & data_gnt_i;
    shd_gnt_o    = sel_shd & data_gnt_i;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (sel_shd) begin
      data_we_o    = 1'b1;
      data_be_o    = 4'b1111;
      data_addr_o  = shd_addr_i;
      data_wdata_o = shd_wdata_i;
    end else if (sel_lsu) begin
      data_we_o    = lsu_we_i;
      data_be_o    = lsu_be_i;
      data_addr_o  = lsu_addr_i;
      data_wdata_o = lsu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Owner FIFO: records who issued each granted request so responses are routed in order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocnt_q   <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel_shd;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   ocnt_q <= ocnt_q + OCNT_W'(1);
        2'b01:   ocnt_q <= ocnt_q - OCNT_W'(1);
        default: ocnt_q <= ocnt_q;
      endcase
    end
  end

`ifdef CV32E40P_SHADOW_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturating count of cycles where the LSU waits behind the shadow port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (lsu_req_i && shd_req_i && sel_shd && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign contention_cnt_o = cnt_q;
`else
  assign contention_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_shadow_mem_arbiter.sv
// Scoreboard bench for cv32e40p_shadow_mem_arbiter: expected response owners are queued at grant.
module tb_cv32e40p_shadow_mem_arbiter;

  localparam int unsigned CNT_WIDTH = 16;
`ifdef CV32E40P_SHADOW_ARB_PERF_EN
  localparam int unsigned EXP_CONT = 5;
`else
  localparam int unsigned EXP_CONT = 0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  logic lsu_req_i, lsu_gnt_o, lsu_rvalid_o, lsu_we_i;
  logic [3:0] lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic shd_req_i, shd_gnt_o, shd_rvalid_o;
  logic [31:0] shd_addr_i, shd_wdata_i;
  logic data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [31:0] data_rdata_i, data_addr_o, data_wdata_o;
  logic [3:0] data_be_o;
  logic [CNT_WIDTH-1:0] contention_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  cv32e40p_shadow_mem_arbiter #(.MAX_OUTSTANDING(2), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .shd_req_i(shd_req_i), .shd_gnt_o(shd_gnt_o), .shd_rvalid_o(shd_rvalid_o),
    .shd_addr_i(shd_addr_i), .shd_wdata_i(shd_wdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .contention_cnt_o(contention_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 4'h0; lsu_addr_i = 0; lsu_wdata_i = 0;
    shd_req_i = 0; shd_addr_i = 0; shd_wdata_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
  endtask

  // Caller has raised data_rvalid_i; compare routing with the oldest queued owner.
  task automatic check_resp(input string tag);
    int e;
    e = (sb.size() != 0) ? sb.pop_front() : 2;
    check({tag, "_lsu_rvalid"}, 32'(lsu_rvalid_o), 32'(e == 0));
    check({tag, "_shd_rvalid"}, 32'(shd_rvalid_o), 32'(e == 1));
  endtask

  task automatic do_reset();
    rst_ni = 0;
    set_idle();
    sb.delete();
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  initial begin
    rst_ni = 0;
    set_idle();
    // reset: outputs quiet even with requests pending
    lsu_req_i = 1; shd_req_i = 1; data_gnt_i = 1; shd_addr_i = 32'h1111_0000;
    data_rdata_i = 32'hA5A5_5A5A;
    tick();
    check("rst_data_req", 32'(data_req_o), 0);
    check("rst_shd_gnt", 32'(shd_gnt_o), 0);
    check("rst_lsu_gnt", 32'(lsu_gnt_o), 0);
    check("rst_addr", data_addr_o, 0);
    check("rst_cnt", 32'(contention_cnt_o), 0);
    check("rst_rdata", lsu_rdata_o, 32'hA5A5_5A5A);
    #2 rst_ni = 1;
    #1;
    check("rel_no_early_req", 32'(data_req_o), 0);
    check("rel_no_early_gnt", 32'(shd_gnt_o), 0);
    set_idle();
    tick();

    // both request in IDLE: shadow wins, LSU next cycle
    lsu_req_i = 1; shd_req_i = 1; data_gnt_i = 1;
    shd_addr_i = 32'h0000_1F00; shd_wdata_i = 32'hCAFE_0001;
    lsu_addr_i = 32'h0000_2000; lsu_we_i = 0; lsu_be_i = 4'b0011;
    #1;
    check("pri_shd_gnt", 32'(shd_gnt_o), 1);
    check("pri_lsu_gnt", 32'(lsu_gnt_o), 0);
    check("pri_addr", data_addr_o, 32'h0000_1F00);
    check("pri_wdata", data_wdata_o, 32'hCAFE_0001);
    check("pri_be", 32'(data_be_o), 32'hF);
    check("pri_we", 32'(data_we_o), 1);
    sb.push_back(1);
    tick();
    shd_req_i = 0;
    #1;
    check("pri_lsu_next_gnt", 32'(lsu_gnt_o), 1);
    check("pri_lsu_addr", data_addr_o, 32'h0000_2000);
    check("pri_lsu_be", 32'(data_be_o), 32'h3);
    check("pri_lsu_we", 32'(data_we_o), 0);
    sb.push_back(0);
    tick();
    // FIFO full: blocked, and a same-cycle pop does not unblock
    #1;
    check("full_req", 32'(data_req_o), 0);
    check("full_gnt", 32'(lsu_gnt_o), 0);
    data_rvalid_i = 1; data_rdata_i = 32'h1234_5678;
    #1;
    check("full_pop_req", 32'(data_req_o), 0);
    check("full_rdata", lsu_rdata_o, 32'h1234_5678);
    check_resp("full_r1");
    tick();
    #1;
    check("unblock_gnt", 32'(lsu_gnt_o), 1);
    check_resp("full_r2");
    sb.push_back(0);
    tick();
    lsu_req_i = 0;
    #1;
    check_resp("full_r3");
    tick();
    set_idle();

    // LSU stalled by data_gnt=0, then shadow arrives: mux must stay on LSU
    lsu_req_i = 1; lsu_addr_i = 32'h0000_3000; lsu_we_i = 1; lsu_be_i = 4'b0001;
    shd_addr_i = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) shd_req_i = 1;
      #1;
      check($sformatf("lock_addr%0d", i), data_addr_o, 32'h0000_3000);
      check($sformatf("lock_req%0d", i), 32'(data_req_o), 1);
      check($sformatf("lock_shd_gnt%0d", i), 32'(shd_gnt_o), 0);
      tick();
    end
    data_gnt_i = 1;
    #1;
    check("lock_lsu_gnt", 32'(lsu_gnt_o), 1);
    check("lock_gnt_addr", data_addr_o, 32'h0000_3000);
    check("lock_gnt_shd", 32'(shd_gnt_o), 0);
    sb.push_back(0);
    tick();
    lsu_req_i = 0;
    #1;
    check("lock_then_shd", 32'(shd_gnt_o), 1);
    check("lock_then_addr", data_addr_o, 32'h0000_4000);
    sb.push_back(1);
    tick();
    shd_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    #1; check_resp("lock_r1"); tick();
    #1; check_resp("lock_r2"); tick();
    set_idle();

    // 10 back-to-back push+pop cycles across pointer wrap
    lsu_req_i = 1; data_gnt_i = 1;
    #1; sb.push_back(0);
    tick();
    for (int i = 0; i < 10; i++) begin
      lsu_req_i = ((i % 2) == 0);
      shd_req_i = ((i % 2) == 1);
      data_rvalid_i = 1;
      #1;
      check_resp($sformatf("b2b%0d", i));
      check($sformatf("b2b_req%0d", i), 32'(data_req_o), 1);
      check($sformatf("b2b_gnt%0d", i), 32'(shd_req_i ? shd_gnt_o : lsu_gnt_o), 1);
      sb.push_back(shd_req_i ? 1 : 0);
      tick();
    end
    lsu_req_i = 0; shd_req_i = 0;
    #1; check_resp("b2b_last");
    tick();
    set_idle();

    // reset while locked on the shadow port with one outstanding
    lsu_req_i = 1; data_gnt_i = 1;
    #1; sb.push_back(0);
    tick();
    lsu_req_i = 0; shd_req_i = 1; data_gnt_i = 0; shd_addr_i = 32'h0000_5000;
    tick();
    rst_ni = 0; data_gnt_i = 1;
    #1;
    check("midrst_req", 32'(data_req_o), 0);
    check("midrst_gnt", 32'(shd_gnt_o), 0);
    check("midrst_addr", data_addr_o, 0);
    check("midrst_be", 32'(data_be_o), 0);
    check("midrst_we", 32'(data_we_o), 0);
    sb.delete();
    tick();
    rst_ni = 1; set_idle();
    tick(); tick();
    data_rvalid_i = 1;
    #1; check_resp("stray");
    tick();
    data_rvalid_i = 0; shd_req_i = 1; data_gnt_i = 1; shd_addr_i = 32'h0000_6000;
    #1;
    check("postrst_gnt", 32'(shd_gnt_o), 1);
    check("postrst_addr", data_addr_o, 32'h0000_6000);
    sb.push_back(1);
    tick();
    shd_req_i = 0; data_rvalid_i = 1;
    #1; check_resp("postrst_r");
    tick();

    // LSU blocked for 5 cycles by a shadow burst
    do_reset();
    lsu_req_i = 1; shd_req_i = 1; data_gnt_i = 1; lsu_addr_i = 32'h0000_7000;
    for (int i = 0; i < 5; i++) begin
      data_rvalid_i = (i != 0);
      #1;
      if (i != 0) check_resp($sformatf("burst_r%0d", i));
      check($sformatf("burst_shd_gnt%0d", i), 32'(shd_gnt_o), 1);
      check($sformatf("burst_lsu_gnt%0d", i), 32'(lsu_gnt_o), 0);
      sb.push_back(1);
      tick();
    end
    shd_req_i = 0; data_rvalid_i = 1;
    #1;
    check_resp("burst_r5");
    check("burst_lsu_after", 32'(lsu_gnt_o), 1);
    check("contention_cnt", 32'(contention_cnt_o), EXP_CONT);
    sb.push_back(0);
    tick();
    lsu_req_i = 0;
    #1;
    check_resp("burst_r6");
    check("contention_hold", 32'(contention_cnt_o), EXP_CONT);
    tick();
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_shadow_mem_arbiter.md
CV32E40P_SHADOW_MEM_ARBITER -- requirements
Module: cv32e40p_shadow_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of granted requests awaiting rvalid (1..4).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the contention counter.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lsu_req_i  input  1  LSU OBI request.
REQ-006 SHALL have port lsu_gnt_o  output  1  LSU grant.
REQ-007 SHALL have port lsu_rvalid_o  output  1  LSU response valid.
REQ-008 SHALL have port lsu_we_i  input  1  LSU write enable.
REQ-009 SHALL have port lsu_be_i  input  4  LSU byte enables.
REQ-010 SHALL have port lsu_addr_i  input  32  LSU address.
REQ-011 SHALL have port lsu_wdata_i  input  32  LSU write data.
REQ-012 SHALL have port lsu_rdata_o  output  32  LSU read data, driven equal to data_rdata_i.
REQ-013 SHALL have port shd_req_i  input  1  shadow-save request; the request is always a full-word write.
REQ-014 SHALL have port shd_gnt_o  output  1  shadow-save grant.
REQ-015 SHALL have port shd_rvalid_o  output  1  shadow-save write response.
REQ-016 SHALL have port shd_addr_i  input  32  shadow-save stack address.
REQ-017 SHALL have port shd_wdata_i  input  32  shadow register data.
REQ-018 SHALL have port data_req_o  output  1  memory OBI request.
REQ-019 SHALL have port data_gnt_i  input  1  memory grant.
REQ-020 SHALL have port data_rvalid_i  input  1  memory response valid.
REQ-021 SHALL have port data_we_o  output  1  memory write enable; driven to 1 when the shadow port is selected.
REQ-022 SHALL have port data_be_o  output  4  memory byte enables; driven to 4'b1111 when the shadow port is selected.
REQ-023 SHALL have port data_addr_o/data_wdata_o  output  32 each  memory address and write data of the selected requester.
REQ-024 SHALL have port contention_cnt_o  output  CNT_WIDTH  count of cycles in which the LSU was blocked by the shadow port.

Function
REQ-025 SHALL implement states IDLE, LOCK_LSU and LOCK_SHD, plus an owner FIFO of depth MAX_OUTSTANDING (one bit per entry: 0 = LSU, 1 = SHD) with an outstanding counter.
REQ-026 SHALL arbitrate in IDLE combinationally, fixed priority SHD > LSU; data_req_o is asserted in the same cycle as the winning req (0-cycle latency), and the grant is passed through as gnt_o = data_gnt_i for the winner only.
REQ-027 SHALL move IDLE to LOCK_x when the winner's request is presented and data_gnt_i=0; in LOCK_x it SHALL drive only requester x and keep the mux stable until data_gnt_i=1, then return to IDLE (OBI request stability).
REQ-028 SHALL, on a handshake data_req_o&data_gnt_i, push the owner ID into the FIFO; on data_rvalid_i it SHALL pop the head and assert only the matching lsu_rvalid_o or shd_rvalid_o in that cycle.
REQ-029 SHALL, on push and pop in the same cycle, keep the outstanding count unchanged and keep FIFO order correct, including pointer wrap-around at MAX_OUTSTANDING.
REQ-030 SHALL, when the FIFO is full, hold data_req_o=0 and both gnt_o=0; a full FIFO with a simultaneous pop does not unblock until the next cycle (registered count).
REQ-031 SHALL keep data_rvalid_i arriving with an empty FIFO as a protocol error: it is dropped, no rvalid_o is asserted, and there is no state change.
REQ-032 SHALL, while lsu_req_i=1, shd_req_i=1 and the shadow port is selected, increment contention_cnt_o by 1 per cycle, saturating at all ones.

Reset
REQ-033 SHALL, on reset assertion at any time including mid-transaction, force state IDLE, FIFO empty, count 0, contention_cnt_o=0 and all outputs 0 (lsu_rdata_o follows data_rdata_i); outstanding responses are forgotten.
REQ-034 SHALL take its first grant no earlier than the first rising edge after rst_ni deasserts.

Configuration
REQ-035 SHALL, with macro CV32E40P_SHADOW_ARB_PERF_EN defined, implement the contention counter as in REQ-032.
REQ-036 SHALL, without CV32E40P_SHADOW_ARB_PERF_EN, remove the counter and tie contention_cnt_o to 0, with all other behaviour identical.

Verification
REQ-037 SHALL cover: lsu_req and shd_req both asserted in IDLE with data_gnt=1 -> shd_gnt=1 and lsu_gnt=0 that cycle, data_addr=shd_addr, data_be=4'b1111, data_we=1; LSU is granted the next cycle.
REQ-038 SHALL cover: LSU request in IDLE with data_gnt=0 for 3 cycles, then shd_req rises -> data_addr stays lsu_addr until the gnt cycle; SHD is served afterwards.
REQ-039 SHALL cover: MAX_OUTSTANDING=2 with two grants (LSU, SHD) and no rvalid -> third request sees data_req=0; two rvalids -> lsu_rvalid then shd_rvalid, in order.
REQ-040 SHALL cover: a push and a pop in the same cycle across 10 back-to-back transactions -> count stays 1 and no rvalid is misrouted across the wrap.
REQ-041 SHALL cover: rst_ni asserted while in LOCK_SHD with 1 outstanding -> all outputs 0 and the FIFO is empty; a later stray data_rvalid produces no rvalid_o.
REQ-042 SHALL cover: with PERF_EN, LSU blocked 5 cycles by a shadow burst -> contention_cnt_o=5; without PERF_EN -> contention_cnt_o=0.
